// File: rtl/aidc_lite_cbuf_pkg.sv
// Shared definitions for the compressed-output buffer commit controller.
//   DEPTH_LOG2   : log2 of buffer entries (16-entry buffer)
//   DW           : buffer word width
//   ptr_t        : buffer pointer with an extra wrap bit
//   cbuf_state_e : write-side state (no open block / open block / overflow)
package aidc_lite_cbuf_pkg;
  localparam int DEPTH_LOG2 = 4;
  localparam int DW         = 64;

  typedef logic [DEPTH_LOG2:0] ptr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    ERR  = 2'd2
  } cbuf_state_e;
endpackage

// File: rtl/aidc_lite_comp_buf_ctrl.sv
// Block-commit controller for the compressed-output buffer. Input words are
// written to the external buffer as they arrive. The output side only sees
// words belonging to blocks already closed by s_last_i.
//
// Optional feature: define AIDC_LITE_CBUF_ABORT_EN to add s_abort_i. This
// discards the open block and clears the overflow error.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   s_valid_i/s_ready_o/s_data_i/s_last_i   input stream (from compressor)
//   s_abort_i                    discard open block (abort builds only)
//   m_valid_o/m_ready_i/m_data_o/m_last_o   output stream (block-committed)
//   buf_wren_o/buf_waddr_o/buf_wdata_o      buffer write port
//   buf_raddr_o/buf_rdata_i      buffer async read port
//   level_o                      words held, committed + open
//   blk_cnt_o                    committed blocks not yet fully drained
//   ovf_err_o                    sticky: an open block filled the buffer
module aidc_lite_comp_buf_ctrl
  import aidc_lite_cbuf_pkg::*;
#(
  parameter int DEPTH_LOG2 = aidc_lite_cbuf_pkg::DEPTH_LOG2,
  parameter int DW         = aidc_lite_cbuf_pkg::DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DW-1:0]         s_data_i,
  input  logic                  s_last_i,
`ifdef AIDC_LITE_CBUF_ABORT_EN
  input  logic                  s_abort_i,
`endif
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DW-1:0]         m_data_o,
  output logic                  m_last_o,
  output logic                  buf_wren_o,
  output logic [DEPTH_LOG2-1:0] buf_waddr_o,
  output logic [DW-1:0]         buf_wdata_o,
  output logic [DEPTH_LOG2-1:0] buf_raddr_o,
  input  logic [DW-1:0]         buf_rdata_i,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic [DEPTH_LOG2:0]   blk_cnt_o,
  output logic                  ovf_err_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] PTR_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  // wptr: next write slot. cptr: end of the last committed block.
  // rptr: next read slot. The wrap bit tells full apart from empty.
  logic [DEPTH_LOG2:0] wptr, cptr, rptr, blk_cnt;
  logic [DEPTH-1:0]    last_q;
  cbuf_state_e         state;
  logic                ovf_err;
  logic                full, abort, push, commit, pop, last_pop;

`ifdef AIDC_LITE_CBUF_ABORT_EN
  assign abort = s_abort_i;
`else
  assign abort = 1'b0;
`endif

  assign level_o   = wptr - rptr;
  assign full      = (level_o == PTR_FULL);
  // Ready comes from registered pointers only. A pop on a full buffer
  // therefore frees the slot for the following cycle.
  assign s_ready_o = !full && (state != ERR) && !abort;
  assign push      = s_valid_i && s_ready_o;
  assign commit    = push && s_last_i;

  assign m_valid_o = (cptr != rptr);
  assign m_last_o  = last_q[rptr[DEPTH_LOG2-1:0]];
  assign m_data_o  = buf_rdata_i;
  assign pop       = m_valid_o && m_ready_i;
  assign last_pop  = pop && m_last_o;

  assign buf_wren_o  = push;
  assign buf_waddr_o = wptr[DEPTH_LOG2-1:0];
  assign buf_wdata_o = s_data_i;
  assign buf_raddr_o = rptr[DEPTH_LOG2-1:0];

  assign blk_cnt_o = blk_cnt;
  assign ovf_err_o = ovf_err;

  // Block-end flags are only read behind cptr, so they need no reset.
  always_ff @(posedge clk) begin
    if (push) last_q[wptr[DEPTH_LOG2-1:0]] <= s_last_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      cptr    <= '0;
      rptr    <= '0;
      blk_cnt <= '0;
      state   <= IDLE;
      ovf_err <= 1'b0;
    end else begin
      if (abort)     wptr <= cptr;
      else if (push) wptr <= wptr + PTR_ONE;
      if (commit)    cptr <= wptr + PTR_ONE;
      if (pop)       rptr <= rptr + PTR_ONE;

      if (commit && !last_pop)      blk_cnt <= blk_cnt + PTR_ONE;
      else if (!commit && last_pop) blk_cnt <= blk_cnt - PTR_ONE;

      if (abort) begin
        state   <= IDLE;
        ovf_err <= 1'b0;
      end else begin
        case (state)
          IDLE, FILL: begin
            // The buffer is full with nothing committed. The open block can
            // never close, so the write side deadlocks.
            if (full && (cptr == rptr)) begin
              state   <= ERR;
              ovf_err <= 1'b1;
            end else if (push) begin
              state <= s_last_i ? IDLE : FILL;
            end
          end
          ERR:     state <= ERR;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aidc_lite_comp_buf_ctrl.sv
module tb_aidc_lite_comp_buf_ctrl;
  localparam int AW = 4;
  localparam int DW = 64;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic [DW-1:0] s_data_i = '0;
  logic          s_last_i = 1'b0;
`ifdef AIDC_LITE_CBUF_ABORT_EN
  logic          s_abort_i = 1'b0;
`endif
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;
  logic          buf_wren_o;
  logic [AW-1:0] buf_waddr_o;
  logic [DW-1:0] buf_wdata_o;
  logic [AW-1:0] buf_raddr_o;
  logic [DW-1:0] buf_rdata_i;
  logic [AW:0]   level_o;
  logic [AW:0]   blk_cnt_o;
  logic          ovf_err_o;

  always #5 clk = ~clk;

  aidc_lite_comp_buf_ctrl dut (
    .clk(clk), .rst(rst),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
`ifdef AIDC_LITE_CBUF_ABORT_EN
    .s_abort_i(s_abort_i),
`endif
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_last_o(m_last_o),
    .buf_wren_o(buf_wren_o), .buf_waddr_o(buf_waddr_o), .buf_wdata_o(buf_wdata_o),
    .buf_raddr_o(buf_raddr_o), .buf_rdata_i(buf_rdata_i),
    .level_o(level_o), .blk_cnt_o(blk_cnt_o), .ovf_err_o(ovf_err_o)
  );

  // 16x64 buffer with async read, as it sits next to the controller.
  logic [DW-1:0] mem [16];
  always @(posedge clk) if (buf_wren_o) mem[buf_waddr_o] <= buf_wdata_o;
  assign buf_rdata_i = mem[buf_raddr_o];

  beat_t exp_q[$];
  beat_t open_q[$];
  beat_t mon_e;
  int    checks = 0;
  int    failures = 0;
  int    rdy_mode = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: handshake inputs are stable between negedge and the next posedge.
  always @(negedge clk) begin
    if (!rst && m_valid_o === 1'b1 && m_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out actual=%0h required=none", m_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", m_data_o, mon_e.d);
        chk("out_last", {63'd0, m_last_o}, {63'd0, mon_e.l});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       m_ready_i = 1'b0;
      1:       m_ready_i = 1'b1;
      default: m_ready_i = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic push_word(input logic [DW-1:0] d, input logic l);
    bit acc = 0;
    int n = 0;
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_last_i  = l;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = s_ready_o;
      tick();
      n++;
    end
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL push_timeout actual=not_accepted required=accepted");
    end else begin
      open_q.push_back('{d: d, l: l});
      if (l) while (open_q.size() != 0) exp_q.push_back(open_q.pop_front());
    end
  endtask

  task automatic drain();
    int n = 0;
    rdy_mode  = 1;
    m_ready_i = 1'b1;
    while ((exp_q.size() != 0 || m_valid_o) && n < 300) begin
      tick();
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("drain_mvalid", {63'd0, m_valid_o}, 64'd0);
    chk("drain_blk_cnt", 64'(blk_cnt_o), 64'd0);
    rdy_mode  = 0;
    m_ready_i = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", {63'd0, s_ready_o}, 64'd1);
    chk("rst_m_valid", {63'd0, m_valid_o}, 64'd0);
    chk("rst_level", 64'(level_o), 64'd0);
    chk("rst_blk_cnt", 64'(blk_cnt_o), 64'd0);
    chk("rst_ovf", {63'd0, ovf_err_o}, 64'd0);
    chk("rst_wren", {63'd0, buf_wren_o}, 64'd0);
    tick();

    // Three-word block: output stays invisible until the last word commits.
    push_word(64'hA, 1'b0);
    push_word(64'hB, 1'b0);
    chk("open_m_valid", {63'd0, m_valid_o}, 64'd0);
    push_word(64'hC, 1'b1);
    chk("commit_m_valid", {63'd0, m_valid_o}, 64'd1);
    chk("commit_blk_cnt", 64'(blk_cnt_o), 64'd1);
    chk("commit_level", 64'(level_o), 64'd3);
    drain();

    // Blocks of 5, 5 and 6 words fill the buffer.
    for (int b = 0; b < 3; b++) begin
      for (int w = 0; w < (b == 2 ? 6 : 5); w++)
        push_word(64'hB000 + 64'(b * 16 + w), (w == (b == 2 ? 5 : 4)));
    end
    chk("full_level", 64'(level_o), 64'd16);
    chk("full_blk_cnt", 64'(blk_cnt_o), 64'd3);
    chk("full_s_ready", {63'd0, s_ready_o}, 64'd0);
    s_valid_i = 1'b1;
    s_data_i  = 64'hF00D;
    s_last_i  = 1'b1;
    m_ready_i = 1'b1;
    @(negedge clk);
    chk("full_pop_cycle_s_ready", {63'd0, s_ready_o}, 64'd0);
    tick();
    @(negedge clk);
    chk("after_pop_s_ready", {63'd0, s_ready_o}, 64'd1);
    chk("after_pop_level", 64'(level_o), 64'd15);
    tick();
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    exp_q.push_back('{d: 64'hF00D, l: 1'b1});
    chk("refill_level", 64'(level_o), 64'd16);
    chk("refill_blk_cnt", 64'(blk_cnt_o), 64'd4);
    drain();

    // Forty single-word blocks with random back-pressure, across pointer wrap.
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) push_word(64'h1000 + 64'(i), 1'b1);
    drain();

    // An open block that fills the buffer deadlocks into the error state.
    for (int i = 0; i < 16; i++) push_word(64'hE000 + 64'(i), 1'b0);
    chk("ovf_level", 64'(level_o), 64'd16);
    tick();
    chk("ovf_err", {63'd0, ovf_err_o}, 64'd1);
    chk("ovf_s_ready", {63'd0, s_ready_o}, 64'd0);
    chk("ovf_m_valid", {63'd0, m_valid_o}, 64'd0);
`ifdef AIDC_LITE_CBUF_ABORT_EN
    s_abort_i = 1'b1;
    tick();
    s_abort_i = 1'b0;
`else
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
`endif
    open_q.delete();
    chk("clr_level", 64'(level_o), 64'd0);
    chk("clr_ovf", {63'd0, ovf_err_o}, 64'd0);
    chk("clr_s_ready", {63'd0, s_ready_o}, 64'd1);

`ifdef AIDC_LITE_CBUF_ABORT_EN
    // Abort discards only the open block; the committed block still drains.
    push_word(64'hD0, 1'b0);
    push_word(64'hD1, 1'b1);
    for (int i = 0; i < 3; i++) push_word(64'hD8 + 64'(i), 1'b0);
    chk("pre_abort_level", 64'(level_o), 64'd5);
    s_abort_i = 1'b1;
    @(negedge clk);
    chk("abort_s_ready", {63'd0, s_ready_o}, 64'd0);
    tick();
    s_abort_i = 1'b0;
    open_q.delete();
    chk("abort_level", 64'(level_o), 64'd2);
    chk("abort_blk_cnt", 64'(blk_cnt_o), 64'd1);
    chk("abort_m_valid", {63'd0, m_valid_o}, 64'd1);
    drain();
`endif

    repeat (3) tick();
    chk("final_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
